sigma_delta_dac_output: RTL and testbench

SIGMA_DELTA_DAC_OUTPUT -- requirements
Module: sigma_delta_dac_output

---
 rtl/sigma_delta_dac_output.sv | 137 +++++++++++++
 tb/tb_sigma_delta_dac_output.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sigma_delta_dac_output.sv
// Second-order delta-sigma DAC: one sample per OSR clocks in, registered 1-bit PDM out.
// One holding register in front of the modulator; an empty holding register at a sample boundary is an underrun.
module sigma_delta_dac_output #(
    parameter int DATA_WIDTH = 12,
    parameter int OSR        = 64
) (
    input  logic                         clk,
    input  logic                         arst,
    input  logic                         enable,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    input  logic                         data_valid,
    output logic                         data_ready,
    output logic                         pdm_out,
    output logic                         underrun,
    output logic [7:0]                   underrun_count
);

    localparam int A1W = DATA_WIDTH + 2;
    localparam int A2W = DATA_WIDTH + 5;
    localparam int CW  = $clog2(OSR);
    localparam logic [CW-1:0] CNT_LAST = CW'(OSR - 1);

    // Feedback +FS and saturation limits, sized to the one-bit-wider sums.
    localparam logic signed [A1W:0] FS1    = {{(A1W-DATA_WIDTH+1){1'b0}}, 1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [A2W:0] FS2    = {{(A2W-DATA_WIDTH+1){1'b0}}, 1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [A1W:0] A1_MAX = {2'b00, {(A1W-1){1'b1}}};
    localparam logic signed [A1W:0] A1_MIN = {2'b11, {(A1W-1){1'b0}}};
    localparam logic signed [A2W:0] A2_MAX = {2'b00, {(A2W-1){1'b1}}};
    localparam logic signed [A2W:0] A2_MIN = {2'b11, {(A2W-1){1'b0}}};

    logic signed [DATA_WIDTH-1:0] hold_q, hold_d, cur_q, cur_d;
    logic                         hold_full_q, hold_full_d;
    logic        [CW-1:0]         cnt_q, cnt_d;
    logic signed [A1W-1:0]        acc1_q, acc1_d;
    logic signed [A2W-1:0]        acc2_q, acc2_d;
    logic                         pdm_q, pdm_d;
    logic                         underrun_q, underrun_d;
    logic        [7:0]            ucnt_q, ucnt_d;

    logic signed [A1W:0]   fb1, acc1_x, cur_x, sum1;
    logic signed [A2W:0]   fb2, acc2_x, a1n_x, sum2;
    logic signed [A1W-1:0] acc1_n;
    logic signed [A2W-1:0] acc2_n;
    logic                  wr, bnd;

    assign wr  = data_valid & ~hold_full_q;
    assign bnd = enable & (cnt_q == CNT_LAST);

    always_comb begin
        fb1    = pdm_q ? FS1 : -FS1;
        fb2    = pdm_q ? FS2 : -FS2;
        acc1_x = {acc1_q[A1W-1], acc1_q};
        cur_x  = {{(A1W+1-DATA_WIDTH){cur_q[DATA_WIDTH-1]}}, cur_q};
        sum1   = acc1_x + cur_x - fb1;
        if (sum1 > A1_MAX)      acc1_n = A1_MAX[A1W-1:0];
        else if (sum1 < A1_MIN) acc1_n = A1_MIN[A1W-1:0];
        else                    acc1_n = sum1[A1W-1:0];
        acc2_x = {acc2_q[A2W-1], acc2_q};
        a1n_x  = {{(A2W+1-A1W){acc1_n[A1W-1]}}, acc1_n};
        sum2   = acc2_x + a1n_x - fb2;
        if (sum2 > A2_MAX)      acc2_n = A2_MAX[A2W-1:0];
        else if (sum2 < A2_MIN) acc2_n = A2_MIN[A2W-1:0];
        else                    acc2_n = sum2[A2W-1:0];
    end

    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        cur_d       = cur_q;
        cnt_d       = cnt_q;
        acc1_d      = acc1_q;
        acc2_d      = acc2_q;
        pdm_d       = pdm_q;
        underrun_d  = 1'b0;
        ucnt_d      = ucnt_q;

        if (enable) begin
            acc1_d = acc1_n;
            acc2_d = acc2_n;
            pdm_d  = ~acc2_n[A2W-1];
            if (bnd) begin
                cnt_d = '0;
                if (hold_full_q) begin
                    cur_d       = hold_q;
                    hold_full_d = 1'b0;
                end else begin
                    underrun_d = 1'b1;
                    if (ucnt_q != 8'hFF) ucnt_d = ucnt_q + 8'd1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d  = '0;
            acc1_d = '0;
            acc2_d = '0;
            cur_d  = '0;
            pdm_d  = ~pdm_q;
        end

        // A write coinciding with an underrun boundary is held for the next boundary, never bypassed.
        if (wr) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cur_q       <= '0;
            cnt_q       <= '0;
            acc1_q      <= '0;
            acc2_q      <= '0;
            pdm_q       <= 1'b0;
            underrun_q  <= 1'b0;
            ucnt_q      <= '0;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            cur_q       <= cur_d;
            cnt_q       <= cnt_d;
            acc1_q      <= acc1_d;
            acc2_q      <= acc2_d;
            pdm_q       <= pdm_d;
            underrun_q  <= underrun_d;
            ucnt_q      <= ucnt_d;
        end
    end

    assign data_ready     = ~hold_full_q;
    assign pdm_out        = pdm_q;
    assign underrun       = underrun_q;
    assign underrun_count = ucnt_q;

endmodule

// File: tb/tb_sigma_delta_dac_output.sv
// Bench for sigma_delta_dac_output: cycle model feeds a scoreboard of expected outputs,
// scenario tasks add density, underrun, handshake and reset checks.
module tb_sigma_delta_dac_output;

    localparam int     DW  = 12;
    localparam int     OSR = 64;
    localparam longint FS  = 2048;
    localparam longint A1MAX = 8191,  A1MIN = -8192;
    localparam longint A2MAX = 65535, A2MIN = -65536;

    logic                 clk = 1'b0;
    logic                 arst = 1'b1;
    logic                 enable = 1'b0;
    logic signed [DW-1:0] data_in = '0;
    logic                 data_valid = 1'b0;
    logic                 data_ready, pdm_out, underrun;
    logic [7:0]           underrun_count;

    int tests = 0;
    int fails = 0;

    sigma_delta_dac_output #(.DATA_WIDTH(DW), .OSR(OSR)) dut (
        .clk(clk), .arst(arst), .enable(enable), .data_in(data_in),
        .data_valid(data_valid), .data_ready(data_ready), .pdm_out(pdm_out),
        .underrun(underrun), .underrun_count(underrun_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         pdm;
        bit         rdy;
        bit         ur;
        logic [7:0] uc;
    } exp_t;

    exp_t sb[$];

    longint m_acc1, m_acc2, m_cur, m_hold;
    int     m_cnt, m_uc;
    bit     m_full, m_pdm, m_ur;

    function automatic longint clamp(longint v, longint lo, longint hi);
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    task automatic model_reset();
        m_acc1 = 0; m_acc2 = 0; m_cur = 0; m_hold = 0;
        m_cnt = 0; m_uc = 0; m_full = 0; m_pdm = 0; m_ur = 0;
    endtask

    task automatic push_exp();
        exp_t e;
        e.pdm = m_pdm; e.rdy = !m_full; e.ur = m_ur; e.uc = 8'(m_uc);
        sb.push_back(e);
    endtask

    always @(posedge arst) begin
        model_reset();
        sb.delete();
    end

    always @(posedge clk) begin
        bit     acc, bnd;
        longint fb, a1, a2;
        if (arst) begin
            model_reset();
        end else begin
            acc  = data_valid && !m_full;
            bnd  = enable && (m_cnt == OSR - 1);
            m_ur = 0;
            if (enable) begin
                fb     = m_pdm ? FS : -FS;
                a1     = clamp(m_acc1 + m_cur - fb, A1MIN, A1MAX);
                a2     = clamp(m_acc2 + a1 - fb, A2MIN, A2MAX);
                m_acc1 = a1;
                m_acc2 = a2;
                m_pdm  = (a2 >= 0);
                if (bnd) begin
                    m_cnt = 0;
                    if (m_full) begin
                        m_cur  = m_hold;
                        m_full = 0;
                    end else begin
                        m_ur = 1;
                        if (m_uc < 255) m_uc++;
                    end
                end else begin
                    m_cnt++;
                end
            end else begin
                m_cnt = 0; m_acc1 = 0; m_acc2 = 0; m_cur = 0;
                m_pdm = !m_pdm;
            end
            if (acc) begin
                m_hold = longint'(data_in);
                m_full = 1;
            end
        end
        push_exp();
    end

    // Pop one expectation per cycle, half a period after the edge that produced it.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            tests++;
            if (pdm_out !== e.pdm || data_ready !== e.rdy || underrun !== e.ur || underrun_count !== e.uc) begin
                fails++;
                $display("FAIL scoreboard t=%0t: got pdm=%b rdy=%b ur=%b uc=%0d, expected pdm=%b rdy=%b ur=%b uc=%0d",
                         $time, pdm_out, data_ready, underrun, underrun_count, e.pdm, e.rdy, e.ur, e.uc);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        arst = 1'b1;
        repeat (3) @(negedge clk);
        arst = 1'b0;
    endtask

    task automatic run(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic count_ones(int n, output int ones);
        ones = 0;
        repeat (n) begin
            @(negedge clk);
            ones += int'(pdm_out);
        end
    endtask

    task automatic check_range(string name, int val, int lo, int hi);
        tests++;
        if (val < lo || val > hi) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d..%0d", name, val, lo, hi);
        end
    endtask

    task automatic test_reset();
        arst = 1'b1;
        run(2);
        #1;
        tests += 4;
        if (pdm_out !== 1'b0)        begin fails++; $display("FAIL reset_pdm: got %b expected 0", pdm_out); end
        if (data_ready !== 1'b1)     begin fails++; $display("FAIL reset_ready: got %b expected 1", data_ready); end
        if (underrun !== 1'b0)       begin fails++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
        if (underrun_count !== 8'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", underrun_count); end
        @(negedge clk);
        arst = 1'b0;
    endtask

    task automatic test_idle();
        logic prev;
        enable = 1'b0; data_valid = 1'b0;
        run(2);
        prev = pdm_out;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            tests++;
            if (pdm_out !== ~prev) begin fails++; $display("FAIL idle_toggle: got %b expected %b", pdm_out, ~prev); end
            prev = pdm_out;
        end
        data_in = 12'sh123; data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        tests++;
        if (data_ready !== 1'b0) begin fails++; $display("FAIL idle_write_ready: got %b expected 0", data_ready); end
        run(3);
    endtask

    task automatic test_density(string name, logic signed [DW-1:0] x, int lo, int hi);
        int ones;
        do_reset();
        enable = 1'b1; data_in = x; data_valid = 1'b1;
        run(16 * OSR);
        count_ones(256, ones);
        check_range(name, ones, lo, hi);
    endtask

    task automatic test_zero();
        int ones;
        do_reset();
        enable = 1'b1; data_in = '0; data_valid = 1'b1;
        run(8 * OSR);
        count_ones(128, ones);
        check_range("density_zero", ones, 62, 66);
    endtask

    task automatic test_fullscale();
        int ones;
        do_reset();
        enable = 1'b1; data_in = 12'sh7FF; data_valid = 1'b1;
        run(16 * OSR);
        count_ones(4 * OSR, ones);
        check_range("density_plus_fs", ones, 250, 256);
        data_in = 12'sh800;
        run(16 * OSR);
        count_ones(4 * OSR, ones);
        check_range("density_minus_fs", ones, 0, 6);
    endtask

    task automatic test_underrun();
        int pulses, ones, waited;
        do_reset();
        enable = 1'b1; data_in = 12'sh400; data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        run(2 * OSR);
        pulses = 0;
        repeat (10 * OSR) begin
            @(negedge clk);
            pulses += int'(underrun);
        end
        check_range("underrun_pulses_per_10_windows", pulses, 10, 10);
        waited = 0;
        while (underrun_count != 8'hFF && waited < 17000) begin
            @(negedge clk);
            waited++;
        end
        tests++;
        if (underrun_count != 8'hFF) begin fails++; $display("FAIL underrun_reach_255: got %0d expected 255", underrun_count); end
        run(3 * OSR);
        tests++;
        if (underrun_count !== 8'hFF) begin fails++; $display("FAIL underrun_saturate: got %0d expected 255", underrun_count); end
        count_ones(256, ones);
        check_range("underrun_last_density", ones, 189, 195);
    endtask

    task automatic test_back_to_back();
        int accepts, lows, waited;
        do_reset();
        enable = 1'b1; data_in = 12'sh0C8; data_valid = 1'b1;
        run(2 * OSR);
        accepts = 0; lows = 0;
        repeat (10 * OSR) begin
            @(negedge clk);
            if (data_valid && data_ready) accepts++;
            if (!data_ready) lows++;
        end
        check_range("b2b_accepts", accepts, 10, 10);
        check_range("b2b_ready_low", lows, 10 * (OSR - 1), 10 * (OSR - 1));
        // Drain the holding register, then write exactly on a boundary edge.
        data_valid = 1'b0;
        run(2 * OSR);
        waited = 0;
        while (m_cnt != OSR - 1 && waited < 2 * OSR) begin
            @(negedge clk);
            waited++;
        end
        tests++;
        if (m_cnt != OSR - 1) begin fails++; $display("FAIL b2b_find_boundary: got cnt %0d expected %0d", m_cnt, OSR - 1); end
        data_in = 12'sh2BC; data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        tests += 2;
        if (underrun !== 1'b1)   begin fails++; $display("FAIL boundary_write_underrun: got %b expected 1", underrun); end
        if (data_ready !== 1'b0) begin fails++; $display("FAIL boundary_write_held: got %b expected 0", data_ready); end
        run(OSR);
        tests += 2;
        if (underrun !== 1'b0)   begin fails++; $display("FAIL next_boundary_no_underrun: got %b expected 0", underrun); end
        if (data_ready !== 1'b1) begin fails++; $display("FAIL next_boundary_consumed: got %b expected 1", data_ready); end
    endtask

    task automatic test_arst_mid();
        int waited;
        do_reset();
        enable = 1'b1; data_in = 12'sh1F4; data_valid = 1'b1;
        run(OSR + OSR / 2);
        waited = 0;
        while (data_ready && waited < 2 * OSR) begin
            @(negedge clk);
            waited++;
        end
        tests++;
        if (data_ready !== 1'b0) begin fails++; $display("FAIL arst_precond_full: got %b expected 0", data_ready); end
        #2 arst = 1'b1;
        #1;
        tests += 3;
        if (pdm_out !== 1'b0)        begin fails++; $display("FAIL arst_pdm: got %b expected 0", pdm_out); end
        if (data_ready !== 1'b1)     begin fails++; $display("FAIL arst_ready: got %b expected 1", data_ready); end
        if (underrun_count !== 8'd0) begin fails++; $display("FAIL arst_count: got %0d expected 0", underrun_count); end
        #1 arst = 1'b0;
        run(3 * OSR);
        enable = 1'b0;
        run(8);
    endtask

    initial begin
        test_reset();
        test_idle();
        test_zero();
        test_density("density_plus_1024", 12'sh400, 189, 195);
        test_density("density_minus_1024", 12'shC00, 61, 67);
        test_fullscale();
        test_back_to_back();
        test_arst_mid();
        test_underrun();
        run(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
